// File: rtl/i2s_pkg.sv
// Constants shared by the I2S capture and transmit paths.
package i2s_pkg;
    localparam int I2S_DATA_W  = 16;
    localparam int I2S_SLOT_W  = 32;
    localparam int I2S_BCK_DIV = 4;

    typedef logic [I2S_DATA_W-1:0] i2s_sample_t;
endpackage

// File: rtl/i2s_bck_gen.sv
// BCK divider: toggles bck every BCK_DIV clks and flags the clk on which bck falls.
module i2s_bck_gen
    import i2s_pkg::*;
#(
    parameter int BCK_DIV = I2S_BCK_DIV
) (
    input  logic clk,
    input  logic nreset,
    input  logic en,
    output logic bck,
    output logic shift_evt
);
    localparam int CW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          wrap;

    assign wrap = (div_cnt == CW'(BCK_DIV - 1));
    // Asserted during the cycle whose closing edge drives bck 1->0.
    assign shift_evt = en && wrap && bck;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            div_cnt <= '0;
            bck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            bck     <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bck     <= ~bck;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter (bus master): one-deep sample hold, frame counter and MSB-first serialiser.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W  = I2S_DATA_W,
    parameter int SLOT_W  = I2S_SLOT_W,
    parameter int BCK_DIV = I2S_BCK_DIV
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              en,
    input  logic [DATA_W-1:0] sample_l,
    input  logic [DATA_W-1:0] sample_r,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              bck,
    output logic              lrck,
    output logic              dout,
    output logic              frame_start,
    output logic              underrun
);
    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int DW         = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

    logic              shift_evt;
    logic [BW-1:0]     bit_cnt, bit_nxt, pos_nxt, data_idx;
    logic              right_nxt, in_data, dout_nxt, boundary, accept;
    logic              hold_full;
    logic [DATA_W-1:0] hold_l, hold_r, active_l, active_r, word;

    i2s_bck_gen #(.BCK_DIV(BCK_DIV)) u_bck_gen (
        .clk      (clk),
        .nreset   (nreset),
        .en       (en),
        .bck      (bck),
        .shift_evt(shift_evt)
    );

    assign sample_ready = ~hold_full;
    assign accept       = sample_valid && ~hold_full;
    assign boundary     = shift_evt && (bit_cnt == LAST_BIT);

    // dout/lrck are registered from the slot position the counter is about to enter.
    always_comb begin
        bit_nxt   = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
        right_nxt = (bit_nxt >= BW'(SLOT_W));
        pos_nxt   = right_nxt ? bit_nxt - BW'(SLOT_W) : bit_nxt;
        in_data   = (pos_nxt != '0) && (pos_nxt <= BW'(DATA_W));
        data_idx  = BW'(DATA_W) - pos_nxt;
        word      = right_nxt ? active_r : active_l;
        dout_nxt  = in_data ? word[data_idx[DW-1:0]] : 1'b0;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_l    <= sample_l;
            hold_r    <= sample_r;
        end else if (boundary && hold_full) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bit_cnt     <= LAST_BIT;
            lrck        <= 1'b0;
            dout        <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            active_l    <= '0;
            active_r    <= '0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (!en) begin
                bit_cnt  <= LAST_BIT;
                lrck     <= 1'b0;
                dout     <= 1'b0;
                active_l <= '0;
                active_r <= '0;
            end else if (shift_evt) begin
                bit_cnt <= bit_nxt;
                lrck    <= right_nxt;
                dout    <= dout_nxt;
                if (boundary) begin
                    frame_start <= 1'b1;
                    // An empty hold repeats the previous pair rather than sending silence.
                    if (hold_full) begin
                        active_l <= hold_l;
                        active_r <= hold_r;
                    end else begin
                        underrun <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
